// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: fetch and load/store requesters, their
// responses, and the single-port memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              d_r;
  logic              d_w;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              err;

  // master is everything around the arbiter: CPU requesters plus the memory
  modport master (
    output if_req, if_addr, d_r, d_w, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, err
  );

  modport slave (
    input  if_req, if_addr, d_r, d_w, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction at a time, fixed read latency, registered read data.
//
// state  | meaning
// IDLE   | arbitrate; issue winner combinationally (mem_en pulse)
// WAIT   | read in flight; capture mem_rdata when counter reaches 1
// RESP   | pulse winner's done, then back to IDLE
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_lat_cnt;
  logic [2:0]        w_lat_cnt_nxt;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [SC_W-1:0]   w_starve_nxt;
  logic              r_win_d;
  logic              w_win_d_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_idle;
  logic              w_d_req;
  logic              w_starved;
  logic              w_grant_if;
  logic              w_grant_d;
  logic              w_issue;
  logic              w_is_wr;
  logic              w_bad_access;
  logic              w_capture;
  logic [ADDR_W-1:0] w_sel_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_d_req    = bus.d_r | bus.d_w;
  assign w_starved  = bus.if_req & (r_starve_cnt == SC_W'(STARVE_MAX));
  assign w_grant_if = w_idle & bus.if_req & (~w_d_req | w_starved);
  assign w_grant_d  = w_idle & w_d_req & ~w_grant_if;
  assign w_issue    = w_grant_if | w_grant_d;
  // d_r and d_w together resolve to a write
  assign w_is_wr    = w_grant_d & bus.d_w;
  assign w_sel_addr = w_grant_d ? bus.d_addr : bus.if_addr;
  assign w_capture  = (r_state == S_WAIT) & (r_lat_cnt == 3'd1);

  assign w_bad_access = w_issue &
                        ((w_grant_d & bus.d_r & bus.d_w) | (w_sel_addr[1:0] != 2'b00));

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_starve_nxt  = r_starve_cnt;
    w_win_d_nxt   = r_win_d;
    w_err_nxt     = r_err | w_bad_access;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_win_d_nxt = w_grant_d;
          if (w_is_wr) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt   = S_WAIT;
            w_lat_cnt_nxt = 3'(MEM_LAT);
          end
          if (w_grant_d & bus.if_req) begin
            if (r_starve_cnt != SC_W'(STARVE_MAX)) begin
              w_starve_nxt = r_starve_cnt + SC_W'(1);
            end
          end else begin
            w_starve_nxt = '0;
          end
        end
      end
      S_WAIT: begin
        w_lat_cnt_nxt = r_lat_cnt - 3'd1;
        if (r_lat_cnt == 3'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_win_d      <= 1'b0;
      r_err        <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_win_d      <= w_win_d_nxt;
      r_err        <= w_err_nxt;
      if (w_capture) begin
        if (r_win_d) begin
          r_d_rdata <= bus.mem_rdata;
        end else begin
          r_if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = w_issue;
  assign bus.mem_we    = w_is_wr;
  assign bus.mem_addr  = w_issue ? {w_sel_addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata = w_is_wr ? bus.d_wdata : '0;

  assign bus.if_rdata = r_if_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.if_done  = (r_state == S_RESP) & ~r_win_d;
  assign bus.d_done   = (r_state == S_RESP) & r_win_d;
  assign bus.busy     = ~w_idle;
  assign bus.err      = r_err;

endmodule
